mem_axi_bridge: RTL and testbench

- Converts the memory stage's single-request bus (valid/ready/req/size/resp) into one AXI4 single-beat read or write transaction.
- Sits directly downstream of the memory stage's CLINT/memory distributor output; its master side connects to the SoC crossbar.
- Handles one outstanding transaction at a time and pulses ready for one cycle on completion.

---
 rtl/mem_axi_bridge_pkg.sv | 24 ++
 rtl/mem_axi_strb_gen.sv | 32 +++
 rtl/mem_axi_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_mem_axi_bridge.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_axi_bridge_pkg.sv
// Shared encodings for the memory-stage to AXI4 bridge: FSM states, access sizes,
// AXI response codes and the burst type used on every transaction.
package mem_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_ERR
    } state_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/mem_axi_strb_gen.sv
// Byte-lane strobe and natural-alignment check for one access, from the size code
// and the low three address bits.
module mem_axi_strb_gen
    import mem_axi_bridge_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [2:0] addr_lo_i,
    output logic [7:0] strb_o,
    output logic       misaligned_o
);

    always_comb begin
        strb_o       = '0;
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_B: strb_o = 8'h01 << addr_lo_i;
            SIZE_H: begin
                strb_o       = 8'h03 << addr_lo_i;
                misaligned_o = addr_lo_i[0];
            end
            SIZE_W: begin
                strb_o       = 8'h0F << addr_lo_i;
                misaligned_o = |addr_lo_i[1:0];
            end
            default: begin
                strb_o       = 8'hFF;
                misaligned_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_axi_bridge.sv
// Converts one memory-stage request into a single-beat AXI4 read or write; one
// transaction outstanding, completion signalled by a one-cycle mem_ready_o pulse.
module mem_axi_bridge
    import mem_axi_bridge_pkg::*;
#(
    parameter int unsigned     ADDR_W = 64,
    parameter int unsigned     DATA_W = 64,
    parameter int unsigned     ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid_i,
    input  logic                mem_req_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [1:0]          mem_size_i,
    input  logic [DATA_W-1:0]   mem_data_write_i,
    output logic                mem_ready_o,
    output logic [DATA_W-1:0]   mem_data_read_o,
    output logic [1:0]          mem_resp_o,
    output logic                axi_aw_valid_o,
    input  logic                axi_aw_ready_i,
    output logic [ADDR_W-1:0]   axi_aw_addr_o,
    output logic [ID_W-1:0]     axi_aw_id_o,
    output logic [2:0]          axi_aw_size_o,
    output logic [7:0]          axi_aw_len_o,
    output logic [1:0]          axi_aw_burst_o,
    output logic                axi_w_valid_o,
    input  logic                axi_w_ready_i,
    output logic [DATA_W-1:0]   axi_w_data_o,
    output logic [DATA_W/8-1:0] axi_w_strb_o,
    output logic                axi_w_last_o,
    input  logic                axi_b_valid_i,
    output logic                axi_b_ready_o,
    input  logic [1:0]          axi_b_resp_i,
    input  logic [ID_W-1:0]     axi_b_id_i,
    output logic                axi_ar_valid_o,
    input  logic                axi_ar_ready_i,
    output logic [ADDR_W-1:0]   axi_ar_addr_o,
    output logic [ID_W-1:0]     axi_ar_id_o,
    output logic [2:0]          axi_ar_size_o,
    output logic [7:0]          axi_ar_len_o,
    output logic [1:0]          axi_ar_burst_o,
    input  logic                axi_r_valid_i,
    output logic                axi_r_ready_o,
    input  logic [DATA_W-1:0]   axi_r_data_i,
    input  logic [1:0]          axi_r_resp_i,
    input  logic [ID_W-1:0]     axi_r_id_i,
    input  logic                axi_r_last_i
);

    state_e                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [1:0]            size_q;
    logic [DATA_W-1:0]     data_q;
    logic [DATA_W/8-1:0]   strb_q;
    logic                  aw_valid_q, w_valid_q, ar_valid_q, b_ready_q, r_ready_q;
    logic                  aw_done_q, w_done_q;
    logic [7:0]            strb_d;
    logic                  misaligned_d;
    logic                  aw_hs, w_hs;

    // IDs and RLAST carry no information for a single outstanding single-beat transfer.
    logic unused_ok;
    assign unused_ok = ^{axi_b_id_i, axi_r_id_i, axi_r_last_i};

    mem_axi_strb_gen u_strb_gen (
        .size_i       (mem_size_i),
        .addr_lo_i    (mem_addr_i[2:0]),
        .strb_o       (strb_d),
        .misaligned_o (misaligned_d)
    );

    assign aw_hs = aw_valid_q & axi_aw_ready_i;
    assign w_hs  = w_valid_q  & axi_w_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_valid_i) begin
                        addr_q <= mem_addr_i;
                        size_q <= mem_size_i;
                        data_q <= mem_data_write_i;
                        strb_q <= strb_d;
                        if (misaligned_d) begin
                            state_q <= ST_ERR;
                        end else if (mem_req_i) begin
                            state_q    <= ST_WR;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            aw_done_q  <= 1'b0;
                            w_done_q   <= 1'b0;
                        end else begin
                            state_q    <= ST_RD_ADDR;
                            ar_valid_q <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (aw_hs) begin
                        aw_valid_q <= 1'b0;
                        aw_done_q  <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid_q <= 1'b0;
                        w_done_q  <= 1'b1;
                    end
                    // Same-cycle handshakes count as done without waiting for the flags.
                    if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                        state_q   <= ST_WR_RESP;
                        b_ready_q <= 1'b1;
                    end
                end
                ST_WR_RESP: begin
                    if (axi_b_valid_i) begin
                        b_ready_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (axi_ar_ready_i) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (axi_r_valid_i) begin
                        r_ready_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_ready_o     = 1'b0;
        mem_resp_o      = RESP_OKAY;
        mem_data_read_o = '0;
        case (state_q)
            ST_WR_RESP: begin
                if (axi_b_valid_i) begin
                    mem_ready_o = 1'b1;
                    mem_resp_o  = axi_b_resp_i;
                end
            end
            ST_RD_DATA: begin
                if (axi_r_valid_i) begin
                    mem_ready_o     = 1'b1;
                    mem_resp_o      = axi_r_resp_i;
                    mem_data_read_o = axi_r_data_i;
                end
            end
            ST_ERR: begin
                mem_ready_o = 1'b1;
                mem_resp_o  = RESP_SLVERR;
            end
            default: ;
        endcase
    end

    assign axi_aw_valid_o = aw_valid_q;
    assign axi_aw_addr_o  = addr_q;
    assign axi_aw_id_o    = AXI_ID;
    assign axi_aw_size_o  = {1'b0, size_q};
    assign axi_aw_len_o   = '0;
    assign axi_aw_burst_o = BURST_INCR;

    assign axi_w_valid_o  = w_valid_q;
    assign axi_w_data_o   = data_q;
    assign axi_w_strb_o   = strb_q;
    assign axi_w_last_o   = 1'b1;

    assign axi_b_ready_o  = b_ready_q;

    assign axi_ar_valid_o = ar_valid_q;
    assign axi_ar_addr_o  = addr_q;
    assign axi_ar_id_o    = AXI_ID;
    assign axi_ar_size_o  = {1'b0, size_q};
    assign axi_ar_len_o   = '0;
    assign axi_ar_burst_o = BURST_INCR;

    assign axi_r_ready_o  = r_ready_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge: a queue-driven AXI slave model plus a
// scoreboard of expected completions (resp, data, completion cycle).
module tb_mem_axi_bridge;

    typedef struct {
        logic [1:0]  resp;
        logic [63:0] data;
        logic        chk_data;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
    } rbeat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_req = 1'b0;
    logic [63:0] mem_addr = '0;
    logic [1:0]  mem_size = '0;
    logic [63:0] mem_wdata = '0;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic [1:0]  mem_resp;

    logic        aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic [63:0] aw_addr, ar_addr, w_data;
    logic [3:0]  aw_id, ar_id;
    logic [2:0]  aw_size, ar_size;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [1:0]  aw_burst, ar_burst;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [1:0]  b_resp = '0;
    logic        ar_valid, r_ready;
    logic        ar_ready = 1'b1;
    logic        r_valid = 1'b0;
    logic [63:0] r_data = '0;
    logic [1:0]  r_resp = '0;

    logic [1:0]  sg_size;
    logic [2:0]  sg_addr;
    logic [7:0]  sg_strb;
    logic        sg_mis;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned aw_delay = 0, w_delay = 0;
    int unsigned aw_cnt = 0, w_cnt = 0;
    int unsigned aw_cyc, w_cyc, ar_cyc, pulses;
    logic        any_valid;
    logic [63:0] cap_aw_addr, cap_w_data, cap_ar_addr;
    logic [7:0]  cap_w_strb, cap_aw_len;
    logic [2:0]  cap_aw_size, cap_ar_size;
    logic [1:0]  cap_aw_burst;
    logic [3:0]  cap_aw_id;
    logic        cap_w_last;

    exp_t        sb[$];
    rbeat_t      rq[$];
    logic [1:0]  bq[$];

    mem_axi_bridge #(.ADDR_W(64), .DATA_W(64), .ID_W(4), .AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid), .mem_req_i(mem_req), .mem_addr_i(mem_addr),
        .mem_size_i(mem_size), .mem_data_write_i(mem_wdata),
        .mem_ready_o(mem_ready), .mem_data_read_o(mem_rdata), .mem_resp_o(mem_resp),
        .axi_aw_valid_o(aw_valid), .axi_aw_ready_i(aw_ready), .axi_aw_addr_o(aw_addr),
        .axi_aw_id_o(aw_id), .axi_aw_size_o(aw_size), .axi_aw_len_o(aw_len),
        .axi_aw_burst_o(aw_burst),
        .axi_w_valid_o(w_valid), .axi_w_ready_i(w_ready), .axi_w_data_o(w_data),
        .axi_w_strb_o(w_strb), .axi_w_last_o(w_last),
        .axi_b_valid_i(b_valid), .axi_b_ready_o(b_ready), .axi_b_resp_i(b_resp),
        .axi_b_id_i(4'd1),
        .axi_ar_valid_o(ar_valid), .axi_ar_ready_i(ar_ready), .axi_ar_addr_o(ar_addr),
        .axi_ar_id_o(ar_id), .axi_ar_size_o(ar_size), .axi_ar_len_o(ar_len),
        .axi_ar_burst_o(ar_burst),
        .axi_r_valid_i(r_valid), .axi_r_ready_o(r_ready), .axi_r_data_i(r_data),
        .axi_r_resp_i(r_resp), .axi_r_id_i(4'd2), .axi_r_last_i(1'b1)
    );

    mem_axi_strb_gen u_sg (
        .size_i(sg_size), .addr_lo_i(sg_addr), .strb_o(sg_strb), .misaligned_o(sg_mis)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Address/data readies assert after the programmed number of waiting cycles.
    assign aw_ready = aw_valid && (aw_cnt >= aw_delay);
    assign w_ready  = w_valid  && (w_cnt  >= w_delay);

    always @(posedge clk) begin
        aw_cnt <= (aw_valid && !aw_ready) ? aw_cnt + 1 : 0;
        w_cnt  <= (w_valid  && !w_ready)  ? w_cnt  + 1 : 0;
    end

    // Response channels: pop on handshake, present the next queued beat 1 ns later.
    always begin
        @(posedge clk);
        if (r_valid && r_ready) void'(rq.pop_front());
        if (b_valid && b_ready) void'(bq.pop_front());
        #1;
        r_valid = (rq.size() != 0);
        if (rq.size() != 0) begin
            r_data = rq[0].data;
            r_resp = rq[0].resp;
        end
        b_valid = (bq.size() != 0);
        if (bq.size() != 0) b_resp = bq[0];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (aw_valid) aw_cyc++;
        if (w_valid)  w_cyc++;
        if (ar_valid) ar_cyc++;
        any_valid = any_valid | aw_valid | w_valid | ar_valid;
        if (aw_valid && aw_ready) begin
            cap_aw_addr = aw_addr; cap_aw_size = aw_size; cap_aw_len = aw_len;
            cap_aw_burst = aw_burst; cap_aw_id = aw_id;
        end
        if (w_valid && w_ready) begin
            cap_w_data = w_data; cap_w_strb = w_strb; cap_w_last = w_last;
        end
        if (ar_valid && ar_ready) begin
            cap_ar_addr = ar_addr; cap_ar_size = ar_size;
        end
        if (mem_ready) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_ready: observed pulse at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mem_resp", 64'(mem_resp), 64'(e.resp));
                if (e.chk_data) chk("mem_rdata", mem_rdata, e.data);
                chk("ready_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic clear_mon();
        aw_cyc = 0; w_cyc = 0; ar_cyc = 0; pulses = 0; any_valid = 1'b0;
        cap_aw_addr = '0; cap_w_data = '0; cap_ar_addr = '0; cap_w_strb = '0;
        cap_aw_len = 8'hFF; cap_aw_size = '0; cap_ar_size = 3'h7; cap_aw_burst = '0;
        cap_aw_id = '0; cap_w_last = 1'b0;
    endtask

    // Called 1 ns after a posedge; holds mem_valid for 'hold' sampling edges.
    task automatic issue(input logic req, input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] wdata, input int unsigned hold);
        mem_valid = 1'b1; mem_req = req; mem_addr = addr; mem_size = size; mem_wdata = wdata;
        repeat (hold) @(posedge clk);
        #1 mem_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout: observed %0d pending, expected 0", tag, sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned k;
        logic [1:0]  tsize [7] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd1, 2'd3};
        logic [2:0]  taddr [7] = '{3'd5, 3'd6, 3'd0, 3'd4, 3'd2, 3'd1, 3'd4};
        logic [7:0]  tstrb [7] = '{8'h20, 8'hC0, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'h00};
        logic        tmis  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valids", 64'({aw_valid, w_valid, ar_valid, b_ready, r_ready}), 64'(0));
        chk("reset_mem_ready", 64'(mem_ready), 64'(0));
        chk("reset_mem_resp", 64'(mem_resp), 64'(0));
        chk("reset_mem_rdata", mem_rdata, 64'(0));

        for (int i = 0; i < 7; i++) begin
            sg_size = tsize[i]; sg_addr = taddr[i];
            #1;
            chk("strb_gen_mis", 64'(sg_mis), 64'(tmis[i]));
            if (!tmis[i]) chk("strb_gen_strb", 64'(sg_strb), 64'(tstrb[i]));
        end

        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Write D, everything immediate.
        clear_mon();
        k = cyc;
        bq.push_back(2'b00);
        sb.push_back('{resp: 2'b00, data: '0, chk_data: 1'b0, cyc: k + 2});
        issue(1'b1, 64'h8000_0010, 2'd3, 64'h1122_3344_5566_7788, 1);
        drain("wr_d");
        chk("wr_d_aw_addr", cap_aw_addr, 64'h8000_0010);
        chk("wr_d_aw_size", 64'(cap_aw_size), 64'(3));
        chk("wr_d_aw_len_burst_id", 64'({cap_aw_len, cap_aw_burst, cap_aw_id}), 64'({8'd0, 2'b01, 4'd1}));
        chk("wr_d_w_strb", 64'(cap_w_strb), 64'hFF);
        chk("wr_d_w_data", cap_w_data, 64'h1122_3344_5566_7788);
        chk("wr_d_w_last", 64'(cap_w_last), 64'(1));
        chk("wr_d_pulses", 64'(pulses), 64'(1));

        // Read B at offset 5.
        clear_mon();
        k = cyc;
        rq.push_back('{data: 64'hAABB_CCDD_EEFF_0011, resp: 2'b00});
        sb.push_back('{resp: 2'b00, data: 64'hAABB_CCDD_EEFF_0011, chk_data: 1'b1, cyc: k + 2});
        issue(1'b0, 64'h8000_0005, 2'd0, 64'h0, 1);
        drain("rd_b");
        chk("rd_b_ar_size", 64'(cap_ar_size), 64'(0));
        chk("rd_b_ar_addr", cap_ar_addr, 64'h8000_0005);
        chk("rd_b_pulses", 64'(pulses), 64'(1));

        // Write H at offset 6 with AW ready held off for 4 cycles.
        clear_mon();
        aw_delay = 4;
        k = cyc;
        bq.push_back(2'b01);
        sb.push_back('{resp: 2'b01, data: '0, chk_data: 1'b0, cyc: k + 6});
        issue(1'b1, 64'h8000_0006, 2'd1, 64'hBEEF_0000_0000_0000, 1);
        drain("wr_h");
        aw_delay = 0;
        chk("wr_h_aw_cycles", 64'(aw_cyc), 64'(5));
        chk("wr_h_w_cycles", 64'(w_cyc), 64'(1));
        chk("wr_h_w_strb", 64'(cap_w_strb), 64'hC0);
        chk("wr_h_pulses", 64'(pulses), 64'(1));

        // Misaligned word write: no AXI traffic, SLVERR next cycle.
        clear_mon();
        k = cyc;
        sb.push_back('{resp: 2'b10, data: '0, chk_data: 1'b0, cyc: k + 1});
        issue(1'b1, 64'h8000_0002, 2'd2, 64'h1234_5678, 1);
        drain("mis_w");
        chk("mis_w_any_valid", 64'(any_valid), 64'(0));
        chk("mis_w_pulses", 64'(pulses), 64'(1));

        // Two back-to-back reads with mem_valid held high.
        clear_mon();
        k = cyc;
        rq.push_back('{data: 64'h0102_0304_0506_0708, resp: 2'b00});
        rq.push_back('{data: 64'hCAFE_F00D_DEAD_BEEF, resp: 2'b11});
        sb.push_back('{resp: 2'b00, data: 64'h0102_0304_0506_0708, chk_data: 1'b1, cyc: k + 2});
        sb.push_back('{resp: 2'b11, data: 64'hCAFE_F00D_DEAD_BEEF, chk_data: 1'b1, cyc: k + 5});
        issue(1'b0, 64'h8000_0100, 2'd3, 64'h0, 4);
        drain("b2b");
        chk("b2b_pulses", 64'(pulses), 64'(2));
        chk("b2b_ar_cycles", 64'(ar_cyc), 64'(2));

        // Reset while waiting for read data.
        clear_mon();
        issue(1'b0, 64'h8000_0200, 2'd3, 64'h0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_r_ready_pending", 64'(r_ready), 64'(1));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valids", 64'({aw_valid, w_valid, ar_valid, b_ready, r_ready}), 64'(0));
        chk("rst_mem_ready", 64'(mem_ready), 64'(0));
        chk("rst_pulses", 64'(pulses), 64'(0));
        @(posedge clk); #1;

        clear_mon();
        k = cyc;
        rq.push_back('{data: 64'h5555_AAAA_1234_4321, resp: 2'b00});
        sb.push_back('{resp: 2'b00, data: 64'h5555_AAAA_1234_4321, chk_data: 1'b1, cyc: k + 2});
        issue(1'b0, 64'h8000_0300, 2'd2, 64'h0, 1);
        drain("post_rst");
        chk("post_rst_pulses", 64'(pulses), 64'(1));
        chk("post_rst_ar_size", 64'(cap_ar_size), 64'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
